weight_fetch_sched: RTL and testbench
=====================================

Name: weight_fetch_sched

Overview:
- Sequences one weight-memory bank group through a layer: triggers the per-layer weight load, waits for it to settle, then streams read addresses to the PE array.
- One controller drives all NUM_BANKS banks in lock-step on shared control and address lines.
- Supports repeated passes over the same weights for input tiling.
- Sits between the layer-level top controller (start/done) and the weight banks/PE array.

Parameters:
- ADDR_WIDTH, 11, bank address width.
- DATA_DEPTH, 2048, words per bank.
- LOAD_WAIT_CYC, 4, idle cycles between load strobe and first read.
- MAX_LAYER, 8, highest valid layer id.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- layer_id  in  4  layer to load (1..MAX_LAYER).
- wt_len  in  ADDR_WIDTH+1  words per bank for this layer (1..DATA_DEPTH).
- rep_num  in  8  passes over the weights; 0 is treated as 1.
- pe_ready  in  1  PE array can take a word next cycle.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle completion pulse.
- err  out  1  sticky config error; cleared by the next accepted start.
- mem_csen  out  1  bank chip select.
- mem_wrenb  out  1  bank load strobe.
- mem_layer_cnt  out  4  layer select to banks.
- mem_rdena  out  1  bank read enable.
- mem_addr_a  out  ADDR_WIDTH  bank read address.
- mem_addr_b  out  ADDR_WIDTH  bank write address; constant 0.
- wt_valid  out  1  bank data_a valid this cycle.
- wt_last  out  1  with wt_valid: last word of a pass.
- rep_idx  out  8  current pass index, 0-based.

Behaviour:
- All outputs are registered and reset to 0. Reset mid-operation returns to IDLE immediately with no done pulse.
- States: IDLE, LOAD, LWAIT, FETCH, FLUSH, FIN.
- IDLE:
  - On start, latch layer_id, wt_len and rep_num (0 becomes 1). Clear err.
  - If layer_id is 0 or greater than MAX_LAYER, or wt_len is 0 or greater than DATA_DEPTH: set err and go to FIN.
  - Otherwise go to LOAD.
- LOAD: exactly one cycle. mem_csen=1, mem_wrenb=1, mem_layer_cnt=latched layer. Then go to LWAIT.
- LWAIT:
  - Counter runs LOAD_WAIT_CYC cycles with csen, wrenb and rdena all 0.
  - mem_layer_cnt holds the latched layer throughout.
  - Then go to FETCH with addr=0 and rep_idx=0.
- FETCH:
  - A read issues in any cycle where pe_ready=1: mem_csen=1, mem_rdena=1, mem_addr_a=addr. Then addr increments.
  - If pe_ready=0, rdena=0 and addr holds. The bank returns 0 in that case, so no valid is generated.
  - When a read issues with addr=wt_len-1: addr wraps to 0 and the issue is tagged last.
  - If that was the final pass (rep_idx=rep_num-1), go to FLUSH; otherwise rep_idx increments.
- Read latency is 1 cycle. wt_valid and wt_last are the issue and last-tag delayed one cycle, aligned with bank data_a.
  - The PE array must accept data whenever wt_valid=1; pe_ready gates issue only.
- FLUSH: one cycle, letting the final wt_valid/wt_last emerge. Then go to FIN.
- FIN: done=1 for one cycle, busy drops in the same cycle, then go to IDLE.
- busy is 0 in IDLE and 1 in every other state except FIN.
- start while not in IDLE is ignored.
- Address arithmetic is ADDR_WIDTH+1 bits wide, so wt_len=DATA_DEPTH reaches address 2047 without overflow.
- rep_idx stays valid until the next accepted start.

Test Plan:
- Basic run, layer_id=2, wt_len=5, rep_num=1, pe_ready=1 constantly:
  - mem_wrenb is high for exactly 1 cycle with mem_layer_cnt=2.
  - 4 quiet cycles follow.
  - Reads issue at addresses 0..4 on consecutive cycles; wt_valid runs 5 cycles starting one cycle after the first read.
  - wt_last is high with the 5th valid; done pulses 2 cycles after the last issue.
- Stall, wt_len=4, pe_ready low for 3 cycles after the 2nd read:
  - mem_addr_a holds at 2 and rdena is 0 during the stall.
  - Exactly 4 valids in total, with no duplicated or skipped address.
- Repeats, wt_len=3, rep_num=3:
  - Address sequence is 0,1,2,0,1,2,0,1,2; rep_idx steps 0→1→2.
  - wt_last is high 3 times; one done pulse.
  - rep_num=0 behaves exactly like rep_num=1.
- Config errors, layer_id=0, then 9, then wt_len=0 (each a separate start):
  - Each run: no wrenb or rdena activity, err=1, done pulses 2 cycles after start.
  - A following valid start clears err.
- Boundary, wt_len=2048, rep_num=2: the last address is 2047, the wrap goes to 0, and 4096 valids occur in total.
- Reset and protocol:
  - Assert rst_n low during FETCH: all outputs are 0 immediately and there is no done pulse.
  - After release, a new start runs normally.
  - A start pulse during busy is ignored.

Source files
------------

// File: rtl/weight_fetch_sched_if.sv
// Handshake and bank-control bundle between the layer controller, the
// weight-fetch scheduler, and the weight banks/PE array.
interface weight_fetch_sched_if #(
  parameter int ADDR_WIDTH = 11
);
  logic                  start;
  logic [3:0]            layer_id;
  logic [ADDR_WIDTH:0]   wt_len;
  logic [7:0]            rep_num;
  logic                  pe_ready;

  logic                  busy;
  logic                  done;
  logic                  err;
  logic                  mem_csen;
  logic                  mem_wrenb;
  logic [3:0]            mem_layer_cnt;
  logic                  mem_rdena;
  logic [ADDR_WIDTH-1:0] mem_addr_a;
  logic [ADDR_WIDTH-1:0] mem_addr_b;
  logic                  wt_valid;
  logic                  wt_last;
  logic [7:0]            rep_idx;

  modport master (
    output start, layer_id, wt_len, rep_num, pe_ready,
    input  busy, done, err, mem_csen, mem_wrenb, mem_layer_cnt, mem_rdena,
           mem_addr_a, mem_addr_b, wt_valid, wt_last, rep_idx
  );

  modport slave (
    input  start, layer_id, wt_len, rep_num, pe_ready,
    output busy, done, err, mem_csen, mem_wrenb, mem_layer_cnt, mem_rdena,
           mem_addr_a, mem_addr_b, wt_valid, wt_last, rep_idx
  );
endinterface

// File: rtl/weight_fetch_sched.sv
// Weight-bank sequencer: one load strobe per layer, a settle window, then
// repeated read-address passes to the PE array with 1-cycle read latency.
module weight_fetch_sched #(
  parameter int ADDR_WIDTH    = 11,
  parameter int DATA_DEPTH    = 2048,
  parameter int LOAD_WAIT_CYC = 4,
  parameter int MAX_LAYER     = 8
) (
  input logic                clk,
  input logic                rst_n,
  weight_fetch_sched_if.slave bus
);

  localparam int LEN_W = ADDR_WIDTH + 1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    LWAIT,
    FETCH,
    FLUSH,
    FIN
  } state_e;

  state_e                state_q;
  logic [3:0]            layer_q;
  logic [LEN_W-1:0]      len_q;
  logic [7:0]            rep_q;
  logic [LEN_W-1:0]      addr_q;
  logic [7:0]            wcnt_q;
  logic                  last_iss_q;

  logic                  busy_q;
  logic                  done_q;
  logic                  err_q;
  logic                  csen_q;
  logic                  wrenb_q;
  logic [3:0]            layer_cnt_q;
  logic                  rdena_q;
  logic [ADDR_WIDTH-1:0] addr_a_q;
  logic                  wt_valid_q;
  logic                  wt_last_q;
  logic [7:0]            rep_idx_q;

  logic cfg_bad;
  assign cfg_bad = (bus.layer_id == 4'd0) || (bus.layer_id > 4'(MAX_LAYER)) ||
                   (bus.wt_len == '0) || (bus.wt_len > LEN_W'(DATA_DEPTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      layer_q     <= '0;
      len_q       <= '0;
      rep_q       <= '0;
      addr_q      <= '0;
      wcnt_q      <= '0;
      last_iss_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      csen_q      <= 1'b0;
      wrenb_q     <= 1'b0;
      layer_cnt_q <= '0;
      rdena_q     <= 1'b0;
      addr_a_q    <= '0;
      wt_valid_q  <= 1'b0;
      wt_last_q   <= 1'b0;
      rep_idx_q   <= '0;
    end else begin
      // Read data follows the issue by one cycle; valid/last ride along with it.
      wt_valid_q <= rdena_q;
      wt_last_q  <= last_iss_q;
      last_iss_q <= 1'b0;
      done_q     <= 1'b0;
      csen_q     <= 1'b0;
      wrenb_q    <= 1'b0;
      rdena_q    <= 1'b0;

      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            layer_q   <= bus.layer_id;
            len_q     <= bus.wt_len;
            rep_q     <= (bus.rep_num == 8'd0) ? 8'd1 : bus.rep_num;
            err_q     <= cfg_bad;
            busy_q    <= 1'b1;
            rep_idx_q <= '0;
            if (cfg_bad) begin
              state_q <= FIN;
            end else begin
              state_q     <= LOAD;
              csen_q      <= 1'b1;
              wrenb_q     <= 1'b1;
              layer_cnt_q <= bus.layer_id;
            end
          end
        end

        LOAD: begin
          state_q <= LWAIT;
          wcnt_q  <= 8'd1;
        end

        // The quiet cycle produced on leaving LOAD counts toward the settle
        // window, so LWAIT itself lasts one cycle less than LOAD_WAIT_CYC.
        LWAIT: begin
          if (wcnt_q >= 8'(LOAD_WAIT_CYC - 1)) begin
            state_q   <= FETCH;
            addr_q    <= '0;
            rep_idx_q <= '0;
          end else begin
            wcnt_q <= wcnt_q + 8'd1;
          end
        end

        FETCH: begin
          addr_a_q <= addr_q[ADDR_WIDTH-1:0];
          if (bus.pe_ready) begin
            csen_q  <= 1'b1;
            rdena_q <= 1'b1;
            if (addr_q == len_q - 1'b1) begin
              last_iss_q <= 1'b1;
              addr_q     <= '0;
              if (rep_idx_q == rep_q - 8'd1) begin
                state_q <= FLUSH;
              end else begin
                rep_idx_q <= rep_idx_q + 8'd1;
              end
            end else begin
              addr_q <= addr_q + 1'b1;
            end
          end
        end

        FLUSH: begin
          state_q  <= FIN;
          addr_a_q <= '0;
        end

        FIN: begin
          state_q     <= IDLE;
          done_q      <= 1'b1;
          busy_q      <= 1'b0;
          layer_cnt_q <= '0;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.err           = err_q;
  assign bus.mem_csen      = csen_q;
  assign bus.mem_wrenb     = wrenb_q;
  assign bus.mem_layer_cnt = layer_cnt_q;
  assign bus.mem_rdena     = rdena_q;
  assign bus.mem_addr_a    = addr_a_q;
  assign bus.mem_addr_b    = '0;
  assign bus.wt_valid      = wt_valid_q;
  assign bus.wt_last       = wt_last_q;
  assign bus.rep_idx       = rep_idx_q;

endmodule

// File: tb/tb_weight_fetch_sched.sv
// Directed bench for weight_fetch_sched: load/settle/fetch timing, stalls,
// repeats, config errors, full-depth boundary, reset and protocol.
module tb_weight_fetch_sched;

  localparam int AW = 11;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  weight_fetch_sched_if #(.ADDR_WIDTH(AW)) bus ();

  weight_fetch_sched #(
    .ADDR_WIDTH   (AW),
    .DATA_DEPTH   (2048),
    .LOAD_WAIT_CYC(4),
    .MAX_LAYER    (8)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Per-run observations, cycle 0 = cycle in which start is high.
  int n_wr, wr_cyc, wr_layer, n_quiet;
  int n_rd, first_rd, last_rd, max_addr, n_stall;
  int n_valid, first_valid, n_last, n_done, done_cyc;
  int addr_err, rep_err, last_err, align_err, busy_err;
  int err_c1, err_done;

  task automatic run(input int lay, input int len, input int rep,
                     input int ss, input int sl, input int rs);
    int exp_addr, exp_rep, rep_eff, safe_len, budget;
    logic prev_rd;
    n_wr = 0; wr_cyc = -1; wr_layer = -1; n_quiet = 0;
    n_rd = 0; first_rd = -1; last_rd = -1; max_addr = 0; n_stall = 0;
    n_valid = 0; first_valid = -1; n_last = 0; n_done = 0; done_cyc = -1;
    addr_err = 0; rep_err = 0; last_err = 0; align_err = 0; busy_err = 0;
    err_c1 = -1; err_done = -1;
    rep_eff  = (rep == 0) ? 1 : rep;
    safe_len = (len == 0) ? 1 : len;
    budget   = 20 + len * rep_eff + sl;
    exp_addr = 0;
    prev_rd  = 1'b0;

    @(negedge clk);
    bus.start    = 1'b1;
    bus.layer_id = 4'(lay);
    bus.wt_len   = 12'(len);
    bus.rep_num  = 8'(rep);
    bus.pe_ready = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;

    for (int k = 1; k < budget; k++) begin
      if (k == 1) err_c1 = int'(bus.err);
      if (bus.busy !== ((done_cyc < 0) && !bus.done)) busy_err++;
      if (n_rd == 0 && n_wr > 0 && k > wr_cyc &&
          !bus.mem_csen && !bus.mem_wrenb && !bus.mem_rdena) n_quiet++;
      if (bus.mem_wrenb) begin
        n_wr++; wr_cyc = k; wr_layer = int'(bus.mem_layer_cnt);
      end
      if (bus.mem_addr_b != '0) addr_err++;
      if (bus.mem_rdena) begin
        n_rd++;
        if (first_rd < 0) first_rd = k;
        last_rd = k;
        if (int'(bus.mem_addr_a) != exp_addr || !bus.mem_csen) addr_err++;
        if (int'(bus.mem_addr_a) > max_addr) max_addr = int'(bus.mem_addr_a);
        exp_rep = n_rd / safe_len;
        if (exp_rep > rep_eff - 1) exp_rep = rep_eff - 1;
        if (int'(bus.rep_idx) != exp_rep) rep_err++;
        exp_addr = (exp_addr + 1) % safe_len;
      end else if (first_rd >= 0 && n_rd < len * rep_eff) begin
        n_stall++;
        if (int'(bus.mem_addr_a) != exp_addr) addr_err++;
      end
      if (bus.wt_valid !== prev_rd) align_err++;
      if (bus.wt_valid) begin
        n_valid++;
        if (first_valid < 0) first_valid = k;
        if (bus.wt_last !== ((n_valid % safe_len) == 0)) last_err++;
      end else if (bus.wt_last) begin
        last_err++;
      end
      if (bus.wt_last) n_last++;
      if (bus.done) begin
        n_done++;
        if (done_cyc < 0) begin
          done_cyc = k; err_done = int'(bus.err);
        end
      end
      prev_rd = bus.mem_rdena;
      if (done_cyc >= 0 && k >= done_cyc + 3) break;
      bus.pe_ready = !(k >= ss && k < ss + sl);
      bus.start    = (k == rs);
      if (k == rs) begin
        bus.layer_id = 4'd7; bus.wt_len = 12'd1; bus.rep_num = 8'd1;
      end
      @(negedge clk);
    end
    bus.start    = 1'b0;
    bus.pe_ready = 1'b1;
  endtask

  task automatic check_clean(input string tag);
    check_eq({tag, "_addr"},  addr_err,  0);
    check_eq({tag, "_align"}, align_err, 0);
    check_eq({tag, "_last"},  last_err,  0);
    check_eq({tag, "_busy"},  busy_err,  0);
    check_eq({tag, "_rep"},   rep_err,   0);
    check_eq({tag, "_ndone"}, n_done,    1);
  endtask

  logic [43:0] outs;
  assign outs = {bus.busy, bus.done, bus.err, bus.mem_csen, bus.mem_wrenb,
                 bus.mem_layer_cnt, bus.mem_rdena, bus.mem_addr_a,
                 bus.mem_addr_b, bus.wt_valid, bus.wt_last, bus.rep_idx};

  initial begin
    int n_done_after;
    bus.start = 1'b0; bus.layer_id = '0; bus.wt_len = '0;
    bus.rep_num = '0; bus.pe_ready = 1'b1;
    #12;
    check_eq("reset_outs", outs, 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    // Basic: layer 2, 5 words, 1 pass
    run(2, 5, 1, 1000, 0, -1);
    check_eq("basic_nwr", n_wr, 1);
    check_eq("basic_wrcyc", wr_cyc, 1);
    check_eq("basic_wrlayer", wr_layer, 2);
    check_eq("basic_quiet", n_quiet, 4);
    check_eq("basic_firstrd", first_rd, 6);
    check_eq("basic_nrd", n_rd, 5);
    check_eq("basic_lastrd", last_rd, 10);
    check_eq("basic_firstvalid", first_valid, 7);
    check_eq("basic_nvalid", n_valid, 5);
    check_eq("basic_nlast", n_last, 1);
    check_eq("basic_donecyc", done_cyc, 12);
    check_eq("basic_err", err_done, 0);
    check_clean("basic");

    // Stall: pe_ready low for 3 cycles after the 2nd read
    run(3, 4, 1, 7, 3, -1);
    check_eq("stall_nrd", n_rd, 4);
    check_eq("stall_nstall", n_stall, 3);
    check_eq("stall_nvalid", n_valid, 4);
    check_eq("stall_lastrd", last_rd, 12);
    check_eq("stall_donecyc", done_cyc, 14);
    check_clean("stall");

    // Repeats: 3 words x 3 passes
    run(1, 3, 3, 1000, 0, -1);
    check_eq("rep_nrd", n_rd, 9);
    check_eq("rep_nlast", n_last, 3);
    check_eq("rep_donecyc", done_cyc, 16);
    check_eq("rep_idx_final", bus.rep_idx, 2);
    check_clean("rep");

    // rep_num = 0 acts as one pass
    run(1, 3, 0, 1000, 0, -1);
    check_eq("rep0_nrd", n_rd, 3);
    check_eq("rep0_nlast", n_last, 1);
    check_eq("rep0_donecyc", done_cyc, 10);
    check_clean("rep0");

    // Config errors
    run(0, 5, 1, 1000, 0, -1);
    check_eq("err_l0_nwr", n_wr + n_rd, 0);
    check_eq("err_l0_err", err_c1, 1);
    check_eq("err_l0_donecyc", done_cyc, 2);
    check_eq("err_l0_busy", busy_err, 0);
    run(9, 5, 1, 1000, 0, -1);
    check_eq("err_l9_nwr", n_wr + n_rd, 0);
    check_eq("err_l9_err", err_done, 1);
    check_eq("err_l9_donecyc", done_cyc, 2);
    run(2, 0, 1, 1000, 0, -1);
    check_eq("err_len0_nwr", n_wr + n_rd, 0);
    check_eq("err_len0_err", err_done, 1);
    check_eq("err_len0_donecyc", done_cyc, 2);
    check_eq("err_sticky", bus.err, 1);
    run(2, 2049, 1, 1000, 0, -1);
    check_eq("err_lenbig_nwr", n_wr + n_rd, 0);
    check_eq("err_lenbig_err", err_done, 1);
    run(8, 2, 1, 1000, 0, -1);
    check_eq("err_clear_c1", err_c1, 0);
    check_eq("err_clear_nrd", n_rd, 2);
    check_eq("err_clear_layer", wr_layer, 8);
    check_clean("errclr");

    // Boundary: full depth, 2 passes
    run(3, 2048, 2, 100000, 0, -1);
    check_eq("bnd_nrd", n_rd, 4096);
    check_eq("bnd_nvalid", n_valid, 4096);
    check_eq("bnd_maxaddr", max_addr, 2047);
    check_eq("bnd_nlast", n_last, 2);
    check_clean("bnd");

    // Start during busy is ignored
    run(2, 5, 1, 1000, 0, 3);
    check_eq("ign_nwr", n_wr, 1);
    check_eq("ign_nrd", n_rd, 5);
    check_eq("ign_donecyc", done_cyc, 12);
    check_eq("ign_idle_busy", bus.busy, 0);
    check_clean("ign");

    // Reset during FETCH
    @(negedge clk);
    bus.start = 1'b1; bus.layer_id = 4'd4; bus.wt_len = 12'd20; bus.rep_num = 8'd1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    check_eq("rst_pre_rdena", bus.mem_rdena, 1);
    rst_n = 1'b0;
    #1;
    check_eq("rst_outs", outs, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n_done_after = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (bus.done || bus.busy || bus.mem_rdena) n_done_after++;
    end
    check_eq("rst_no_activity", n_done_after, 0);
    run(2, 5, 1, 1000, 0, -1);
    check_eq("rst_after_nrd", n_rd, 5);
    check_eq("rst_after_donecyc", done_cyc, 12);
    check_clean("rstafter");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
